instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 19 +
 rtl/instruction_fetch_unit_pc_next_sel.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset PC and bubble word.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        START     = 2'd0,
        FETCH     = 2'd1,
        MISS_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_WORD      = 32'h0000_0000;
    localparam logic [15:0] MISS_COUNT_MAX   = 16'hFFFF;

    // Instructions are word aligned; the two low address bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next_sel.sv
// Next-PC selection: redirect beats pending redirect beats sequential step, else hold.
module pc_next_sel
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_STEP = 4
) (
    input  logic [31:0] pc,
    input  logic        use_redirect,
    input  logic [31:0] redirect_target,
    input  logic        use_pending,
    input  logic [31:0] pending_target,
    input  logic        advance,
    output logic [31:0] pc_next
);

    // Priority select of the next fetch address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_next = pc;
        if (use_redirect) begin
            pc_next = align_pc(redirect_target);
        end else if (use_pending) begin
            pc_next = align_pc(pending_target);
        end else if (advance) begin
            pc_next = align_pc(pc + 32'(PC_STEP));
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the I-cache, waits out misses, handles redirects and stalls.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        icache_read,
    output logic [9:0]  icache_pc,
    input  logic [31:0] icache_instruction,
    input  logic        icache_busywait,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic [15:0] miss_count
);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic         pending_valid;
    logic [31:0]  pending_target;

    logic use_redirect, use_pending, advance;
    logic capture, flush, latch_pending, clear_pending, count_miss;

    pc_next_sel #(.PC_STEP(PC_STEP)) u_pc_next_sel (
        .pc              (pc),
        .use_redirect    (use_redirect),
        .redirect_target (redirect_target),
        .use_pending     (use_pending),
        .pending_target  (pending_target),
        .advance         (advance),
        .pc_next         (pc_next)
    );

    assign icache_pc = pc[9:0];

    // Next-state and per-edge control decisions.
    always_comb begin
        state_next    = state;
        icache_read   = 1'b1;
        use_redirect  = 1'b0;
        use_pending   = 1'b0;
        advance       = 1'b0;
        capture       = 1'b0;
        flush         = 1'b0;
        latch_pending = 1'b0;
        clear_pending = 1'b0;
        count_miss    = 1'b0;

        case (state)
            START: begin
                icache_read = 1'b0;
                if (stall) begin
                    latch_pending = redirect;
                end else begin
                    state_next = FETCH;
                    if (redirect) begin
                        use_redirect  = 1'b1;
                        clear_pending = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (stall) begin
                    latch_pending = redirect;
                end else if (redirect) begin
                    use_redirect  = 1'b1;
                    flush         = 1'b1;
                    clear_pending = 1'b1;
                end else if (icache_busywait) begin
                    state_next = MISS_WAIT;
                    flush      = 1'b1;
                    count_miss = 1'b1;
                end else if (pending_valid) begin
                    use_pending   = 1'b1;
                    flush         = 1'b1;
                    clear_pending = 1'b1;
                end else begin
                    capture = 1'b1;
                    advance = 1'b1;
                end
            end
            MISS_WAIT: begin
                // The cache decodes icache_pc during refill, so pc must not move while busy.
                if (stall || icache_busywait) begin
                    latch_pending = redirect;
                end else begin
                    state_next = FETCH;
                    if (redirect) begin
                        use_redirect  = 1'b1;
                        flush         = 1'b1;
                        clear_pending = 1'b1;
                    end else if (pending_valid) begin
                        use_pending   = 1'b1;
                        flush         = 1'b1;
                        clear_pending = 1'b1;
                    end else begin
                        capture = 1'b1;
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_next  = START;
                icache_read = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // PC, pending redirect, fetch result and miss counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc             <= RESET_PC;
            pending_valid  <= 1'b0;
            pending_target <= RESET_PC;
            if_instr       <= BUBBLE_WORD;
            if_pc          <= 32'h0;
            if_valid       <= 1'b0;
            miss_count     <= 16'h0;
        end else begin
            pc <= pc_next;
            if (latch_pending) begin
                pending_valid  <= 1'b1;
                pending_target <= align_pc(redirect_target);
            end else if (clear_pending) begin
                pending_valid <= 1'b0;
            end
            if (capture) begin
                if_instr <= icache_instruction;
                if_pc    <= pc;
                if_valid <= 1'b1;
            end else if (flush) begin
                if_valid <= 1'b0;
            end
            if (count_miss && miss_count != MISS_COUNT_MAX) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios then random traffic vs a reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_read;
    logic [9:0]  icache_pc;
    logic [31:0] icache_instruction;
    logic        icache_busywait;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk                (clk),
        .reset              (reset),
        .icache_read        (icache_read),
        .icache_pc          (icache_pc),
        .icache_instruction (icache_instruction),
        .icache_busywait    (icache_busywait),
        .stall              (stall),
        .redirect           (redirect),
        .redirect_target    (redirect_target),
        .if_instr           (if_instr),
        .if_pc              (if_pc),
        .if_valid           (if_valid),
        .miss_count         (miss_count)
    );

    always #5 clk = ~clk;

    // Cache stand-in: the word returned is the 10-bit fetch address, zero extended.
    assign icache_instruction = {22'h0, icache_pc};

    // Reference model (fetch phase: 0 = just out of reset, 1 = fetching, 2 = waiting on a miss).
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_if_instr;
    logic [31:0] m_if_pc;
    logic        m_if_valid;
    logic        m_pend_v;
    logic [31:0] m_pend_t;
    int          m_miss;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Apply one rising edge to the model with the given inputs.
    task automatic model_edge(input logic rst, input logic bw, input logic st,
                              input logic rd, input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (!rst) begin
            m_phase = 0; m_pc = RESET_PC; m_if_instr = 0; m_if_pc = 0;
            m_if_valid = 0; m_pend_v = 0; m_miss = 0;
        end else if (st) begin
            if (rd) begin m_pend_v = 1; m_pend_t = t; end
        end else if (m_phase == 0) begin
            m_phase = 1;
            if (rd) begin m_pc = t; m_pend_v = 0; end
        end else if (m_phase == 2 && bw) begin
            if (rd) begin m_pend_v = 1; m_pend_t = t; end
        end else if (m_phase == 1 && !rd && bw) begin
            m_phase = 2; m_if_valid = 0;
            if (m_miss < 65535) m_miss++;
        end else begin
            // A fetch completes this edge (hit, or miss refill finished).
            m_phase = 1;
            if (rd) begin
                m_pc = t; m_if_valid = 0; m_pend_v = 0;
            end else if (m_pend_v) begin
                m_pc = m_pend_t; m_if_valid = 0; m_pend_v = 0;
            end else begin
                m_if_instr = {22'h0, m_pc[9:0]};
                m_if_pc    = m_pc;
                m_if_valid = 1;
                m_pc       = m_pc + PC_STEP;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic bw, input logic st,
                         input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        reset = rst; icache_busywait = bw; stall = st; redirect = rd; redirect_target = tgt;
        #1;
        check("icache_read", 32'(icache_read), 32'(m_phase != 0));
        check("icache_pc", 32'(icache_pc), 32'(m_pc[9:0]));
        model_edge(rst, bw, st, rd, tgt);
        @(posedge clk);
        #1;
        check("if_valid", 32'(if_valid), 32'(m_if_valid));
        check("if_pc", if_pc, m_if_pc);
        check("if_instr", if_instr, m_if_instr);
        check("miss_count", 32'(miss_count), 32'(m_miss));
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
    endtask

    initial begin
        reset = 0; icache_busywait = 0; stall = 0; redirect = 0; redirect_target = 0;
        m_phase = 0; m_pc = RESET_PC; m_if_instr = 0; m_if_pc = 0;
        m_if_valid = 0; m_pend_v = 0; m_pend_t = 0; m_miss = 0;

        // Reset release and streaming hits: if_pc 0, 4, 8, 12.
        do_reset();
        hits(5);
        check("stream_last_pc", if_pc, 32'hC);

        // Miss at pc 0x10 held busy for 5 cycles, then captured.
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 32'h0);
        check("miss_wait_icache_pc", 32'(icache_pc), 32'h010);
        cycle(1, 0, 0, 0, 32'h0);
        check("miss_capture_pc", if_pc, 32'h10);
        check("miss_count_one", 32'(miss_count), 32'd1);

        // Redirect to 0x40 while fetching at pc 0x08.
        do_reset();
        hits(3);
        cycle(1, 0, 0, 1, 32'h40);
        hits(2);

        // Redirect to 0x80 arriving during a miss.
        cycle(1, 1, 0, 0, 32'h0);
        cycle(1, 1, 0, 1, 32'h80);
        cycle(1, 1, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 32'h0);
        hits(2);

        // Stall for 3 cycles with if_pc at 0x20, redirect latched during stall.
        cycle(1, 0, 0, 1, 32'h20);
        hits(1);
        for (int i = 0; i < 3; i++) cycle(1, i == 1, 1, 0, 32'h0);
        hits(1);
        cycle(1, 0, 1, 1, 32'h300);
        cycle(1, 0, 1, 1, 32'h123);
        hits(3);

        // Wrap through the top of the address space; low target bits ignored.
        cycle(1, 0, 0, 1, 32'hFFFF_FFFB);
        hits(3);

        // Reset asserted mid-miss with a pending redirect.
        cycle(1, 1, 0, 0, 32'h0);
        cycle(1, 1, 0, 1, 32'h200);
        cycle(0, 1, 0, 0, 32'h0);
        check("reset_mid_miss_read", 32'(icache_read), 32'd0);
        hits(4);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic rst, bw, st, rd;
            logic [31:0] tgt;
            rst = ($urandom_range(0, 99) >= 2);
            bw  = ($urandom_range(0, 99) < 30);
            st  = ($urandom_range(0, 99) < 20);
            rd  = ($urandom_range(0, 99) < 10);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cycle(rst, bw, st, rd, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
